// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface fetch_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, IF/ID register,
// one-word skid buffer for responses that land while decode is stalled.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   ISSUE | request pc_f on the bus, waiting for a grant
//   WAIT  | granted, waiting for read data to move into IF/ID
//   BUF   | data arrived during a stall, parked in buf_q until release
//   DROP  | redirected while a request is in flight; next rvalid is stale
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pc_write_zero,
    input  logic                IF_pipeline_write_zero,
    input  logic                branch_taken,
    input  logic [15:0]         dest_pc,
    fetch_unit_if.master        imem,
    output logic [31:0]         instr_D,
    output logic [15:0]         pc_D,
    output logic                valid_D
);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_BUF   = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] pc_f;
    logic [31:0] buf_q;
    logic        stall;
    logic        redir;
    logic        transfer;
    logic        capture;
    logic [31:0] xfer_word;
    logic [15:0] dest_aligned;

    assign stall        = pc_write_zero | IF_pipeline_write_zero;
    assign redir        = branch_taken & ~stall;
    assign dest_aligned = dest_pc & 16'hFFFC;

    // Request is only raised in ISSUE; suppressed while reset is held.
    assign imem.imem_req  = (state_q == S_ISSUE) & ~reset;
    assign imem.imem_addr = pc_f;

    // Next-state selection plus transfer/capture strobes for the datapath.
    always_comb begin
        state_d   = state_q;
        transfer  = 1'b0;
        capture   = 1'b0;
        xfer_word = imem.imem_rdata;
        case (state_q)
            S_ISSUE: begin
                if (imem.imem_gnt) begin
                    state_d = redir ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (redir) begin
                    state_d = imem.imem_rvalid ? S_ISSUE : S_DROP;
                end else if (imem.imem_rvalid) begin
                    if (stall) begin
                        capture = 1'b1;
                        state_d = S_BUF;
                    end else begin
                        transfer = 1'b1;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_BUF: begin
                if (redir) begin
                    state_d = S_ISSUE;
                end else if (!stall) begin
                    transfer  = 1'b1;
                    xfer_word = buf_q;
                    state_d   = S_ISSUE;
                end
            end
            S_DROP: begin
                if (imem.imem_rvalid) begin
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_ISSUE;
        endcase
    end

    // State register; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_ISSUE;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, skid buffer and IF/ID register; redirect outranks transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f    <= RESET_PC;
            buf_q   <= '0;
            instr_D <= NOP_INSTR;
            pc_D    <= 16'h0000;
            valid_D <= 1'b0;
        end else begin
            if (capture) begin
                buf_q <= imem.imem_rdata;
            end
            if (redir) begin
                pc_f    <= dest_aligned;
                instr_D <= NOP_INSTR;
                pc_D    <= dest_aligned;
                valid_D <= 1'b0;
            end else if (transfer) begin
                instr_D <= xfer_word;
                pc_D    <= pc_f;
                valid_D <= 1'b1;
                pc_f    <= pc_f + 16'd4;
            end else if (!stall) begin
                instr_D <= NOP_INSTR;
                valid_D <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 16'h0000, byte address of the first fetch after reset.
REQ-002 Parameter NOP_INSTR, 32'h00000013, word loaded into the IF/ID register on bubble or flush.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 pc_write_zero  in  1  from the hazard detection unit; 1 = hold the fetch PC.
REQ-006 IF_pipeline_write_zero  in  1  from the hazard detection unit; 1 = hold the IF/ID register.
REQ-007 branch_taken  in  1  redirect request from the decode stage.
REQ-008 dest_pc  in  16  redirect target byte address.
REQ-009 imem_req  out  1  instruction-memory request.
REQ-010 imem_addr  out  16  request byte address; equals the fetch PC (pc_f).
REQ-011 imem_gnt  in  1  request accepted this cycle.
REQ-012 imem_rvalid  in  1  read data valid.
REQ-013 imem_rdata  in  32  read data.
REQ-014 instr_D  out  32  IF/ID instruction, registered.
REQ-015 pc_D  out  16  IF/ID PC, registered.
REQ-016 valid_D  out  1  IF/ID holds a real instruction.

Function
REQ-017 stall = pc_write_zero | IF_pipeline_write_zero; redir = branch_taken & ~stall.
REQ-018 States: ISSUE, WAIT, BUF, DROP.
REQ-019 imem_req = 1 only in ISSUE; imem_addr and imem_req remain stable until imem_gnt.
REQ-020 At most one memory request is outstanding; a response arrives at least 1 cycle after grant.
REQ-021 ISSUE: gnt & ~redir -> WAIT; gnt & redir -> DROP; ~gnt & redir -> stay ISSUE.
REQ-022 WAIT: rvalid & ~stall & ~redir -> transfer, ISSUE; rvalid & stall -> capture word in buffer, BUF.
REQ-023 WAIT: redir & ~rvalid -> DROP; redir & rvalid -> discard word, ISSUE.
REQ-024 BUF: ~stall & ~redir -> transfer the buffered word, ISSUE; redir -> discard buffer, ISSUE; stall -> stay BUF.
REQ-025 DROP: rvalid -> discard word, ISSUE; otherwise stay DROP.
REQ-026 Transfer: instr_D <= word; pc_D <= pc_f; valid_D <= 1; pc_f <= pc_f + 4.
REQ-027 PC arithmetic is 16-bit modulo; 16'hFFFC + 4 wraps to 16'h0000.
REQ-028 On redir in any state: pc_f <= {dest_pc[15:2], 2'b00}; instr_D <= NOP_INSTR; valid_D <= 0.
REQ-029 On redir, pc_D <= dest_pc aligned, as don't-care debug information.
REQ-030 Redirect wins over a same-cycle transfer; the transferred word is never delivered.
REQ-031 Bubble: ~stall, ~redir and no transfer -> instr_D <= NOP_INSTR and valid_D <= 0; pc_D holds.
REQ-032 While stall = 1, instr_D, pc_D, valid_D and pc_f hold, and branch_taken is ignored.
REQ-033 In stall, a memory response arriving in WAIT is buffered and never lost or duplicated.
REQ-034 Latency: with zero-wait memory (gnt on request, rvalid the next cycle), the IF/ID register loads 2 cycles after the first request; steady throughput is 1 instruction per 2 cycles.

Reset
REQ-035 While reset = 1: state = ISSUE, pc_f = RESET_PC, imem_req = 0, instr_D = NOP_INSTR, pc_D = 16'h0000, valid_D = 0, buffer cleared.
REQ-036 Reset asserted mid-transaction abandons any outstanding request; a later rvalid is ignored until a new grant occurs.
REQ-037 imem_req asserts with imem_addr = RESET_PC in the first cycle after reset deasserts.

Verification
REQ-038 Reset release, zero-wait memory returning 32'h00A00093 at 0 -> imem_addr 0, 4, 8 in sequence; instr_D = 32'h00A00093, pc_D = 0, valid_D = 1 two cycles after the first request.
REQ-039 stall = 1 for 3 cycles, with rvalid arriving in WAIT -> IF/ID holds and the state enters BUF; after release the buffered word loads once, and pc_f advances by exactly 4.
REQ-040 branch_taken with dest_pc = 16'h0042 while in WAIT -> DROP; the stale response is discarded; the next imem_addr is 16'h0040; instr_D = 32'h00000013 and valid_D = 0 for the flush cycle.
REQ-041 branch_taken with stall = 1 -> no redirect; pc_f is unchanged, and the branch is honored once stall drops with branch_taken still 1.
REQ-042 pc_f = 16'hFFFC, transfer -> next imem_addr = 16'h0000.
REQ-043 Memory with 3-cycle rvalid latency, ID not stalled -> IF/ID holds NOP with valid_D = 0 during the gaps; no instruction is duplicated or skipped.
